// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl: frame sequencer for a bank of conv_layer units.
// Counts word credits into the shared input FIFO, fires one start pulse per
// frame once a full frame is buffered, tracks the frame load, waits for all
// convs to report valid, hands results downstream and retires them with yumi.
//
// Ports
//   clk_i          single clock, rising edge
//   reset_ni       asynchronous active-low reset (deassertion synchronised)
//   fifo_wen_i     write strobe into the shared input FIFO
//   fifo_full_i    input FIFO full
//   fifo_ren_i     read strobe from the conv units (lead conv ready_o)
//   fifo_empty_i   input FIFO empty
//   conv_valid_i   per-conv valid_o, NUM_CONVS wide
//   start_o        one-cycle start pulse broadcast to all convs
//   conv_yumi_o    one-cycle yumi broadcast to all convs
//   valid_o        all conv results valid (downstream handshake)
//   ready_i        downstream accepts results
//   busy_o         controller not idle
//   frame_count_o  completed frames, wraps modulo 2^FRAME_CNT_W
//   error_o        sticky error (credit underflow, stray read, watchdog)
//
// Build option
//   CONV_LAYER_CTRL_TIMEOUT_EN  when defined, adds the TIMEOUT_CYCLES parameter
//   and a COMPUTE watchdog that flushes the convs and returns to IDLE.
//
// start_o, valid_o, busy_o and conv_yumi_o are decoded from the state register
// (conv_yumi_o also from ready_i) so they follow the handshake in the same cycle.

module conv_layer_ctrl #(
    parameter int unsigned INPUT_LAYER_HEIGHT = 4,
    parameter int unsigned KERNEL_WIDTH       = 2,
    parameter int unsigned NUM_CONVS          = 2,
    parameter int unsigned FRAME_CNT_W        = 16
`ifdef CONV_LAYER_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES     = 255
`endif
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   fifo_wen_i,
    input  logic                   fifo_full_i,
    input  logic                   fifo_ren_i,
    input  logic                   fifo_empty_i,
    input  logic [NUM_CONVS-1:0]   conv_valid_i,
    output logic                   start_o,
    output logic                   conv_yumi_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   busy_o,
    output logic [FRAME_CNT_W-1:0] frame_count_o,
    output logic                   error_o
);

    localparam int unsigned FRAME_WORDS = INPUT_LAYER_HEIGHT * KERNEL_WIDTH;
    localparam int unsigned CREDIT_MAX  = 2 * FRAME_WORDS;
    localparam int unsigned CREDIT_W    = $clog2(CREDIT_MAX + 1);
    localparam int unsigned LOAD_W      = $clog2(FRAME_WORDS + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_OUTPUT  = 3'd4;

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic [1:0]             r_rst_sync;
    logic [CREDIT_W-1:0]    r_credit;
    logic [LOAD_W-1:0]      r_load_cnt;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic                   r_error;

    logic w_run;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_underflow;
    logic w_rd_stray;
    logic w_all_valid;
    logic w_frame_done;
    logic w_timeout;
    logic w_credit_full;
    logic w_frame_ready;
    logic w_load_last;

    // Handshake qualification
    assign w_wr_acc      = fifo_wen_i & ~fifo_full_i;
    assign w_rd_acc      = fifo_ren_i & ~fifo_empty_i;
    assign w_all_valid   = &conv_valid_i;
    assign w_credit_full = (r_credit == CREDIT_W'(CREDIT_MAX));
    assign w_frame_ready = (r_credit >= CREDIT_W'(FRAME_WORDS));
    assign w_load_last   = (r_load_cnt == LOAD_W'(FRAME_WORDS - 1));

    // A read with no credit left and no simultaneous write is an underflow
    assign w_underflow   = w_rd_acc & ~w_wr_acc & (r_credit == '0);
    // Reads are only expected while a frame is being loaded
    assign w_rd_stray    = w_rd_acc & (r_state != S_LOAD);
    assign w_frame_done  = (r_state == S_OUTPUT) & ready_i;

    // Two-flop reset release; the FSM stays in IDLE until it completes
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_run = r_rst_sync[1];

`ifdef CONV_LAYER_CTRL_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog;

    // Counts COMPUTE cycles already elapsed; fires in the TIMEOUT_CYCLES-th one
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wdog <= '0;
        end else if ((r_state == S_COMPUTE) && !w_all_valid && !w_timeout) begin
            r_wdog <= r_wdog + WDOG_W'(1);
        end else begin
            r_wdog <= '0;
        end
    end

    assign w_timeout = (r_state == S_COMPUTE) && !w_all_valid &&
                       (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Word credit: net writes minus reads, saturating high, held on underflow
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_credit <= '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            if (!w_credit_full) begin
                r_credit <= r_credit + CREDIT_W'(1);
            end
        end else if (!w_wr_acc && w_rd_acc) begin
            if (r_credit != '0) begin
                r_credit <= r_credit - CREDIT_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_run && w_frame_ready) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                w_next_state = S_LOAD;
            end
            S_LOAD: begin
                if (w_rd_acc && w_load_last) begin
                    w_next_state = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (w_all_valid) begin
                    w_next_state = S_OUTPUT;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_OUTPUT: begin
                if (ready_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Words read so far in the current frame
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_load_cnt <= '0;
        end else if (r_state == S_START) begin
            r_load_cnt <= '0;
        end else if ((r_state == S_LOAD) && w_rd_acc) begin
            r_load_cnt <= r_load_cnt + LOAD_W'(1);
        end
    end

    // Completed frames; a watchdog flush does not count
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_frame_count <= '0;
        end else if (w_frame_done) begin
            r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
        end
    end

    // Sticky error, cleared only by reset
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_error <= 1'b0;
        end else if (w_underflow || w_rd_stray || w_timeout) begin
            r_error <= 1'b1;
        end
    end

    // State decodes; the watchdog flush reuses yumi to drain the convs
    assign start_o       = (r_state == S_START);
    assign valid_o       = (r_state == S_OUTPUT);
    assign busy_o        = (r_state != S_IDLE);
    assign conv_yumi_o   = w_frame_done | w_timeout;
    assign frame_count_o = r_frame_count;
    assign error_o       = r_error;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Self-checking bench for conv_layer_ctrl (default parameters).
// Randomised write/read gaps, conv latency and downstream ready delay; the
// expected behaviour comes from frame-level rules (credits, frame counts,
// event spacing) kept in the bench.

module tb_conv_layer_ctrl;

    localparam int FW    = 8;
    localparam int DEPTH = 64;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        fifo_wen_i = 1'b0;
    logic        fifo_full_i = 1'b0;
    logic        fifo_ren_i = 1'b0;
    logic        fifo_empty_i = 1'b1;
    logic [1:0]  conv_valid_i = 2'b00;
    logic        ready_i = 1'b0;
    logic        start_o;
    logic        conv_yumi_o;
    logic        valid_o;
    logic        busy_o;
    logic [15:0] frame_count_o;
    logic        error_o;

    conv_layer_ctrl #(
        .INPUT_LAYER_HEIGHT(4),
        .KERNEL_WIDTH(2),
        .NUM_CONVS(2),
        .FRAME_CNT_W(16)
`ifdef CONV_LAYER_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(20)
`endif
    ) u_dut (
        .clk_i(clk_i),
        .reset_ni(reset_ni),
        .fifo_wen_i(fifo_wen_i),
        .fifo_full_i(fifo_full_i),
        .fifo_ren_i(fifo_ren_i),
        .fifo_empty_i(fifo_empty_i),
        .conv_valid_i(conv_valid_i),
        .start_o(start_o),
        .conv_yumi_o(conv_yumi_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .busy_o(busy_o),
        .frame_count_o(frame_count_o),
        .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side model state
    int occ = 0;            // words sitting in the FIFO
    int exp_fc = 0;         // expected completed frames
    int exp_starts = 0;     // frames the bench expects to have been started
    int consumed = 0;       // start pulses already claimed by a frame
    bit force_full = 1'b0;

    // Observed events
    int cyc_n = 0;
    int n_start = 0;
    int n_yumi = 0;
    int n_overlap = 0;
    int last_start_cyc = -1;
    int last_yumi_cyc = -1;
    int last_wr_cyc = -1;
    int start_busy = 0;
    bit acc_w, acc_r;
    int s_start, s_yumi, s_valid, s_busy, s_fc, s_err;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // One clock: drive inputs after the edge, then sample settled outputs
    task automatic cyc(input bit wen, input bit ren, input logic [1:0] cv, input bit rdy);
        @(posedge clk_i);
        #1;
        fifo_full_i  = (occ >= DEPTH) || force_full;
        fifo_empty_i = (occ == 0);
        fifo_wen_i   = wen;
        fifo_ren_i   = ren;
        conv_valid_i = cv;
        ready_i      = rdy;
        acc_w = wen && !fifo_full_i;
        acc_r = ren && !fifo_empty_i;
        #1;
        cyc_n++;
        s_start = int'(start_o);
        s_yumi  = int'(conv_yumi_o);
        s_valid = int'(valid_o);
        s_busy  = int'(busy_o);
        s_fc    = int'(frame_count_o);
        s_err   = int'(error_o);
        if (start_o) begin
            n_start++;
            last_start_cyc = cyc_n;
            start_busy = int'(busy_o);
        end
        if (conv_yumi_o) begin
            n_yumi++;
            last_yumi_cyc = cyc_n;
        end
        if (start_o && conv_yumi_o) n_overlap++;
        if (acc_w) last_wr_cyc = cyc_n;
        occ = occ + int'(acc_w) - int'(acc_r);
    endtask

    task automatic write_words(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 2'b00, 1'b0);
            cyc(1'b1, 1'b0, 2'b00, 1'b0);
        end
    endtask

    // Wait (bounded) for the next start pulse; exp < 0 skips the timing check
    task automatic wait_start(input int exp, input bit hold);
        int guard = 0;
        while (n_start <= consumed && guard < 100) begin
            cyc(1'b0, 1'b0, 2'b00, hold);
            guard++;
        end
        check("start_seen", int'(n_start > consumed), 1);
        consumed = n_start;
        exp_starts++;
        if (exp >= 0) check("start_time", last_start_cyc, exp);
        check("busy_at_start", start_busy, 1);
    endtask

    task automatic load_reads(input int n, input bit hold);
        int rd = 0;
        int guard = 0;
        int bad = 0;
        while (rd < n && guard < 200) begin
            cyc(1'b0, ($urandom_range(0, 3) != 0), 2'b00, hold);
            if (acc_r) rd++;
            if (s_valid != 0 || s_yumi != 0 || s_start != 0) bad++;
            guard++;
        end
        check("load_reads", rd, n);
        check("load_quiet", bad, 0);
    endtask

    task automatic do_frame(input int exp_start, input int lat, input int rdy_dly,
                            input bit hold, input bit fixed01);
        int bad = 0;
        int y0;
        int wait_n;
        wait_start(exp_start, hold);
        load_reads(FW, hold);
        for (int i = 0; i < lat; i++) begin
            cyc(1'b0, 1'b0, fixed01 ? 2'b01 : 2'($urandom_range(0, 2)), hold);
            if (s_valid != 0 || s_yumi != 0 || s_busy != 1) bad++;
        end
        check("compute_wait", bad, 0);
        y0 = n_yumi;
        cyc(1'b0, 1'b0, 2'b11, hold);
        check("valid_pre", s_valid, 0);
        wait_n = hold ? 0 : rdy_dly;
        for (int j = 0; j <= wait_n; j++) begin
            cyc(1'b0, 1'b0, 2'b11, hold || (j == wait_n));
            if (j == 0) check("valid_rise", s_valid, 1);
            if (j < wait_n) check("yumi_hold", s_yumi, 0);
        end
        check("yumi_on_ready", s_yumi, 1);
        check("fc_before", s_fc, exp_fc);
        check("yumi_count", n_yumi - y0, 1);
        exp_fc = (exp_fc + 1) % 65536;
        cyc(1'b0, 1'b0, 2'b00, hold);
        check("idle_after", s_busy, 0);
        check("frame_count", s_fc, exp_fc);
    endtask

    initial begin
        int c0;
        int s0;
        int busy_hi;

        // Reset state
        #1;
        check("rst_start", int'(start_o), 0);
        check("rst_yumi", int'(conv_yumi_o), 0);
        check("rst_valid", int'(valid_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_fc", int'(frame_count_o), 0);
        check("rst_err", int'(error_o), 0);
        @(posedge clk_i);
        #3 reset_ni = 1'b1;
        repeat (5) cyc(1'b0, 1'b0, 2'b00, 1'b0);

        // Seven words plus a write against a full FIFO: not enough for a frame
        write_words(7, 1'b1);
        force_full = 1'b1;
        cyc(1'b1, 1'b0, 2'b00, 1'b0);
        force_full = 1'b0;
        busy_hi = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0, 2'b00, 1'b0);
            busy_hi += s_busy;
        end
        check("short_no_start", n_start, 0);
        check("short_not_busy", busy_hi, 0);

        // Eighth word, partial valid for 10 cycles then all valid
        write_words(1, 1'b0);
        do_frame(last_wr_cyc + 2, 10, 2, 1'b0, 1'b1);

        // Randomised single frames
        for (int f = 0; f < 4; f++) begin
            write_words(FW, 1'b1);
            do_frame(last_wr_cyc + 2, $urandom_range(0, 15), $urandom_range(0, 4), 1'b0, 1'b0);
        end

        // Two frames preloaded, ready held high, back to back
        c0 = cyc_n;
        write_words(2 * FW, 1'b0);
        do_frame(c0 + FW + 2, $urandom_range(0, 6), 0, 1'b1, 1'b0);
        do_frame(last_yumi_cyc + 2, $urandom_range(0, 6), 0, 1'b1, 1'b0);
        s0 = n_start;
        repeat (20) cyc(1'b0, 1'b0, 2'b00, 1'b0);
        check("credit_drained", n_start - s0, 0);
        check("fc_two_frames", s_fc, exp_fc);

`ifdef CONV_LAYER_CTRL_TIMEOUT_EN
        // Watchdog: convs never report valid
        begin
            int early = 0;
            int y0;
            write_words(FW, 1'b1);
            wait_start(last_wr_cyc + 2, 1'b0);
            load_reads(FW, 1'b0);
            y0 = n_yumi;
            for (int k = 1; k <= 20; k++) begin
                cyc(1'b0, 1'b0, 2'b00, 1'b0);
                if (k < 20 && s_yumi != 0) early++;
            end
            check("to_early", early, 0);
            check("to_yumi", s_yumi, 1);
            cyc(1'b0, 1'b0, 2'b00, 1'b0);
            check("to_idle", s_busy, 0);
            check("to_err", s_err, 1);
            check("to_fc", s_fc, exp_fc);
            check("to_yumi_count", n_yumi - y0, 1);
        end
`else
        // Without the watchdog a slow conv bank is simply waited for
        write_words(FW, 1'b1);
        do_frame(last_wr_cyc + 2, 300, 1, 1'b0, 1'b0);
`endif

        // Reset in the middle of a load
        write_words(FW, 1'b1);
        wait_start(last_wr_cyc + 2, 1'b0);
        begin
            int rd = 0;
            int guard = 0;
            while (rd < 3 && guard < 50) begin
                cyc(1'b0, 1'b1, 2'b00, 1'b0);
                if (acc_r) rd++;
                guard++;
            end
        end
        ready_i = 1'b1;
        conv_valid_i = 2'b11;
        reset_ni = 1'b0;
        #1;
        check("mid_rst_start", int'(start_o), 0);
        check("mid_rst_yumi", int'(conv_yumi_o), 0);
        check("mid_rst_valid", int'(valid_o), 0);
        check("mid_rst_busy", int'(busy_o), 0);
        check("mid_rst_fc", int'(frame_count_o), 0);
        check("mid_rst_err", int'(error_o), 0);
        exp_fc = 0;
        repeat (2) cyc(1'b0, 1'b0, 2'b00, 1'b0);
        @(posedge clk_i);
        #3 reset_ni = 1'b1;
        repeat (4) cyc(1'b0, 1'b0, 2'b00, 1'b0);
        s0 = n_start;
        write_words(FW - 1, 1'b1);
        repeat (20) cyc(1'b0, 1'b0, 2'b00, 1'b0);
        check("post_rst_no_start", n_start - s0, 0);
        write_words(1, 1'b0);
        do_frame(last_wr_cyc + 2, $urandom_range(0, 8), $urandom_range(0, 3), 1'b0, 1'b0);

        // Stray read while idle: error sets and sticks
        check("err_clean", s_err, 0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0);
        check("stray_read_taken", int'(acc_r), 1);
        cyc(1'b0, 1'b0, 2'b00, 1'b0);
        check("err_set", s_err, 1);
        write_words(3, 1'b1);
        repeat (5) cyc(1'b0, 1'b0, 2'b00, 1'b0);
        check("err_sticky", s_err, 1);

        check("start_total", n_start, exp_starts);
        check("start_yumi_overlap", n_overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout: bench did not complete (cycle %0d)", cyc_n);
        $fatal(1);
    end

endmodule
